// File: rtl/inst_cache.sv
// inst_cache: direct-mapped read-only instruction cache with word-by-word line refill
// Optional hit/miss counters are added when ICACHE_STATS_EN is defined.
module inst_cache #(
  parameter int ADDR_WIDTH = 32,
  parameter int INDEX_BITS = 6,
  parameter int LINE_WORDS = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  rdy_in,
  input  logic                  if_icache_en_in,
  input  logic [ADDR_WIDTH-1:0] if_icache_inst_addr_in,
  output logic                  icache_if_rdy_out,
  output logic                  icache_if_miss_out,
  output logic [31:0]           icache_if_inst_inst_out,
  input  logic                  rob_icache_flush_in,
  output logic                  icache_mem_en_out,
  output logic [ADDR_WIDTH-1:0] icache_mem_addr_out,
  input  logic                  mem_icache_valid_in,
  input  logic [31:0]           mem_icache_data_in
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]           icache_hit_cnt_out,
  output logic [31:0]           icache_miss_cnt_out
`endif
);
  localparam int WB = $clog2(LINE_WORDS);
  localparam int OB = WB + 2;
  localparam int TW = ADDR_WIDTH - OB - INDEX_BITS;
  localparam int LINES = 1 << INDEX_BITS;
  typedef enum logic [1:0] {IDLE, LOOKUP, REFILL} state_t;
  state_t state, state_nx;
  logic [ADDR_WIDTH-1:0] addr_q, addr_nx, mem_addr_nx;
  logic [WB-1:0] beat, beat_nx, beat_inc, a_off;
  logic [31:0] cap, cap_nx, inst_nx;
  logic flushed, flushed_nx, rdy_nx, miss_nx, mem_en_nx;
  logic [LINES-1:0] valid;
  logic [TW-1:0] tag_mem [LINES];
  logic [31:0] data_mem [LINES*LINE_WORDS];
  logic [INDEX_BITS-1:0] a_idx;
  logic [TW-1:0] a_tag;
  logic hit, beat_in, last_beat, unused_addr;
  assign unused_addr = ^addr_q[1:0];
  assign a_off = addr_q[OB-1:2];
  assign a_idx = addr_q[OB+INDEX_BITS-1:OB];
  assign a_tag = addr_q[ADDR_WIDTH-1:OB+INDEX_BITS];
  assign hit = valid[a_idx] && tag_mem[a_idx] == a_tag;
  assign beat_in = state == REFILL && mem_icache_valid_in;
  assign last_beat = beat_in && beat == WB'(LINE_WORDS - 1);
  assign beat_inc = beat + WB'(1);
  // next-state and next registered-output values
  always_comb begin
    state_nx = state;
    addr_nx = addr_q;
    beat_nx = beat;
    flushed_nx = flushed;
    rdy_nx = icache_if_rdy_out;
    miss_nx = 1'b1;
    inst_nx = icache_if_inst_inst_out;
    mem_en_nx = icache_mem_en_out;
    mem_addr_nx = icache_mem_addr_out;
    cap_nx = beat_in && beat == a_off ? mem_icache_data_in : cap;
    case (state)
      IDLE: if (if_icache_en_in && !rob_icache_flush_in) begin
        state_nx = LOOKUP;
        addr_nx = if_icache_inst_addr_in;
        rdy_nx = 1'b0;
      end
      LOOKUP: if (rob_icache_flush_in) begin
        state_nx = IDLE;
        rdy_nx = 1'b1;
      end else if (hit) begin
        state_nx = IDLE;
        rdy_nx = 1'b1;
        miss_nx = 1'b0;
        inst_nx = data_mem[{a_idx, a_off}];
      end else begin
        state_nx = REFILL;
        mem_en_nx = 1'b1;
        mem_addr_nx = {addr_q[ADDR_WIDTH-1:OB], {OB{1'b0}}};
        beat_nx = '0;
        flushed_nx = 1'b0;
      end
      REFILL: begin
        flushed_nx = flushed | rob_icache_flush_in;
        if (beat_in) begin
          beat_nx = beat_inc;
          mem_addr_nx = {icache_mem_addr_out[ADDR_WIDTH-1:OB], beat_inc, 2'b00};
        end
        if (last_beat) begin
          state_nx = IDLE;
          mem_en_nx = 1'b0;
          rdy_nx = 1'b1;
          miss_nx = flushed_nx;
          inst_nx = cap_nx;
        end
      end
      default: state_nx = IDLE;
    endcase
  end
  // control state and outputs, frozen while rdy_in is low
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      state <= IDLE;
      addr_q <= '0;
      beat <= '0;
      cap <= '0;
      flushed <= 1'b0;
      valid <= '0;
      icache_if_rdy_out <= 1'b1;
      icache_if_miss_out <= 1'b1;
      icache_if_inst_inst_out <= '0;
      icache_mem_en_out <= 1'b0;
      icache_mem_addr_out <= '0;
    end else if (rdy_in) begin
      state <= state_nx;
      addr_q <= addr_nx;
      beat <= beat_nx;
      cap <= cap_nx;
      flushed <= flushed_nx;
      if (last_beat) valid[a_idx] <= 1'b1;
      icache_if_rdy_out <= rdy_nx;
      icache_if_miss_out <= miss_nx;
      icache_if_inst_inst_out <= inst_nx;
      icache_mem_en_out <= mem_en_nx;
      icache_mem_addr_out <= mem_addr_nx;
    end
  // line data and tag storage, written as refill beats arrive
  always_ff @(posedge clk_in)
    if (rdy_in && beat_in) begin
      data_mem[{a_idx, beat}] <= mem_icache_data_in;
      if (last_beat) tag_mem[a_idx] <= a_tag;
    end
`ifdef ICACHE_STATS_EN
  // hit/miss counters, one count per unflushed lookup resolution
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      icache_hit_cnt_out <= '0;
      icache_miss_cnt_out <= '0;
    end else if (rdy_in && state == LOOKUP && !rob_icache_flush_in) begin
      if (hit) icache_hit_cnt_out <= icache_hit_cnt_out + 32'd1;
      else icache_miss_cnt_out <= icache_miss_cnt_out + 32'd1;
    end
`endif
endmodule

// File: tb/tb_inst_cache.sv
// tb_inst_cache: directed self-checking bench for inst_cache
module tb_inst_cache;
  logic clk_in = 1'b0;
  logic rst_n_in, rdy_in, en, flush_main, flush_auto, mem_valid;
  logic [31:0] addr, mem_data, inst, mem_addr;
  logic rdy, miss, mem_en;
  wire flush = flush_main | flush_auto;
  int tests = 0, fails = 0, reads = 0, flush_on = -1;
  logic [31:0] addr_log [64];
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif
  always #5 clk_in = ~clk_in;
  inst_cache dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
    .if_icache_en_in(en), .if_icache_inst_addr_in(addr),
    .icache_if_rdy_out(rdy), .icache_if_miss_out(miss), .icache_if_inst_inst_out(inst),
    .rob_icache_flush_in(flush), .icache_mem_en_out(mem_en), .icache_mem_addr_out(mem_addr),
    .mem_icache_valid_in(mem_valid), .mem_icache_data_in(mem_data)
`ifdef ICACHE_STATS_EN
    , .icache_hit_cnt_out(hit_cnt), .icache_miss_cnt_out(miss_cnt)
`endif
  );
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a[31:4] == 28'h0000100 ? 32'hA0 + 32'(a[3:2]) : a ^ 32'hDEAD_0000;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  // memory responder: one-cycle valid pulse every other cycle while a read is requested
  initial begin
    mem_valid = 1'b0;
    mem_data = '0;
    flush_auto = 1'b0;
    forever begin
      @(negedge clk_in);
      flush_auto = 1'b0;
      if (mem_valid) mem_valid = 1'b0;
      else if (mem_en && rdy_in && rst_n_in) begin
        mem_valid = 1'b1;
        mem_data = mem_word(mem_addr);
        addr_log[reads % 64] = mem_addr;
        reads++;
        if (reads == flush_on) flush_auto = 1'b1;
      end
    end
  end
  task automatic fetch(input string tag, input logic [31:0] a, input logic [31:0] exp, input int exp_reads, input int exp_lat);
    int r0, lat;
    r0 = reads;
    lat = 0;
    @(negedge clk_in);
    en = 1'b1;
    addr = a;
    @(negedge clk_in);
    en = 1'b0;
    while (miss && lat < 60) begin
      @(negedge clk_in);
      lat++;
    end
    chk({tag, "_inst"}, inst, exp);
    chk({tag, "_rdy"}, 32'(rdy), 32'd1);
    chk({tag, "_reads"}, 32'(reads - r0), 32'(exp_reads));
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    @(negedge clk_in);
    chk({tag, "_miss_back"}, 32'(miss), 32'd1);
  endtask
  initial begin
    int r0, n;
    logic saw;
    #100000;
    $display("FAIL watchdog timeout got running exp finished");
    $fatal(1);
  end
  initial begin
    int r0, n;
    logic saw;
    rst_n_in = 1'b0;
    rdy_in = 1'b1;
    en = 1'b0;
    flush_main = 1'b0;
    addr = '0;
    repeat (3) @(negedge clk_in);
    chk("rst_rdy", 32'(rdy), 32'd1);
    chk("rst_miss", 32'(miss), 32'd1);
    chk("rst_inst", inst, 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    rst_n_in = 1'b1;
    r0 = reads;
    fetch("cold", 32'h0000_1008, 32'hA2, 4, 8);
    for (int i = 0; i < 4; i++) chk("cold_addr", addr_log[(r0 + i) % 64], 32'h1000 + 32'(4 * i));
    fetch("hit", 32'h0000_100C, 32'hA3, 0, 1);
`ifdef ICACHE_STATS_EN
    chk("stat_hit", hit_cnt, 32'd1);
    chk("stat_miss", miss_cnt, 32'd1);
`endif
    r0 = reads;
    fetch("evict", 32'h0000_1408, 32'hDEAD_1408, 4, 8);
    chk("evict_addr", addr_log[r0 % 64], 32'h1400);
    fetch("refetch", 32'h0000_1008, 32'hA2, 4, 8);
    r0 = reads;
    flush_on = reads + 2;
    saw = 1'b0;
    @(negedge clk_in);
    en = 1'b1;
    addr = 32'h0000_2000;
    @(negedge clk_in);
    en = 1'b0;
    repeat (30) begin
      @(negedge clk_in);
      if (!miss) saw = 1'b1;
    end
    flush_on = -1;
    chk("flush_no_resp", 32'(saw), 32'd0);
    chk("flush_reads", 32'(reads - r0), 32'd4);
    chk("flush_rdy", 32'(rdy), 32'd1);
    fetch("flush_hit", 32'h0000_2004, 32'hDEAD_2004, 0, 1);
    r0 = reads;
    @(negedge clk_in);
    en = 1'b1;
    flush_main = 1'b1;
    addr = 32'h0000_5000;
    @(negedge clk_in);
    en = 1'b0;
    flush_main = 1'b0;
    chk("idle_flush_rdy", 32'(rdy), 32'd1);
    repeat (3) @(negedge clk_in);
    chk("idle_flush_mem_en", 32'(mem_en), 32'd0);
    chk("idle_flush_reads", 32'(reads - r0), 32'd0);
    r0 = reads;
    @(negedge clk_in);
    en = 1'b1;
    addr = 32'h0000_300C;
    @(negedge clk_in);
    en = 1'b0;
    n = 0;
    while (reads - r0 < 2 && n < 40) begin
      @(posedge clk_in);
      #2;
      n++;
    end
    rdy_in = 1'b0;
    repeat (3) begin
      @(negedge clk_in);
      chk("stall_mem_en", 32'(mem_en), 32'd1);
      chk("stall_mem_addr", mem_addr, 32'h3008);
    end
    @(posedge clk_in);
    #2;
    rdy_in = 1'b1;
    n = 0;
    while (miss && n < 60) begin
      @(negedge clk_in);
      n++;
    end
    chk("stall_inst", inst, 32'hDEAD_300C);
    chk("stall_reads", 32'(reads - r0), 32'd4);
    @(negedge clk_in);
    @(negedge clk_in);
    en = 1'b1;
    addr = 32'h0000_4000;
    @(negedge clk_in);
    en = 1'b0;
    n = 0;
    while (!mem_en && n < 40) begin
      @(posedge clk_in);
      #2;
      n++;
    end
    chk("arst_pre_mem_en", 32'(mem_en), 32'd1);
    #1;
    rst_n_in = 1'b0;
    #1;
    chk("arst_mem_en", 32'(mem_en), 32'd0);
    chk("arst_mem_addr", mem_addr, 32'd0);
    chk("arst_rdy", 32'(rdy), 32'd1);
    chk("arst_miss", 32'(miss), 32'd1);
    chk("arst_inst", inst, 32'd0);
    @(negedge clk_in);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    fetch("arst_refill", 32'h0000_4000, 32'hDEAD_4000, 4, 8);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/inst_cache.md
Name: inst_cache

Overview:
- Instruction cache: the responder end of the fetch-to-icache request interface. Memory-side initiator toward the memory controller.
- Direct-mapped, read-only. Line refill is done word-by-word from the memory controller.
- Supplies one 32-bit instruction per accepted fetch request. Honours the ready/miss semantics the fetch unit relies on.

Parameters:
- ADDR_WIDTH, 32, address width.
- INDEX_BITS, 6, log2 of line count (64 lines).
- LINE_WORDS, 4, 32-bit words per line; power of 2, ≥2.

Ports:
- clk_in  input  1  clock
- rst_n_in  input  1  asynchronous active-low reset
- rdy_in  input  1  global enable; when low, all state and outputs hold
- if_icache_en_in  input  1  fetch request
- if_icache_inst_addr_in  input  ADDR_WIDTH  fetch address; bits[1:0] ignored
- icache_if_rdy_out  output  1  cache can accept a request this cycle
- icache_if_miss_out  output  1  low for exactly one cycle when inst_out is valid
- icache_if_inst_inst_out  output  32  instruction
- rob_icache_flush_in  input  1  cancel outstanding request (mispredict)
- icache_mem_en_out  output  1  memory read request, level
- icache_mem_addr_out  output  ADDR_WIDTH  word-aligned read address
- mem_icache_valid_in  input  1  one-cycle pulse, data for current address
- mem_icache_data_in  input  32  returned word

Behaviour:
- Address split, offset width OB = log2(LINE_WORDS)+2:
  - word offset = addr[OB-1:2]
  - index = addr[OB+INDEX_BITS-1:OB]
  - tag = remaining upper bits
- Storage: per-line valid bit, tag, and data words.
- All outputs are registered.
- Reset values: rdy_out=1, miss_out=1, inst_out=0, mem_en_out=0, mem_addr_out=0, all valid bits=0, state=IDLE.
- FSM states: IDLE, LOOKUP, REFILL.
- IDLE:
  - rdy_out=1.
  - On en_in & !flush_in: latch addr, rdy_out<=0, go to LOOKUP.
  - en_in while rdy_out=0 is ignored.
- LOOKUP:
  - Hit (valid & tag match): inst_out<=word, miss_out<=0, rdy_out<=1, go to IDLE.
  - Hit latency: request sampled at edge k, instruction valid in the cycle after edge k+1.
  - Miss: mem_en_out<=1, mem_addr_out<=line base, beat counter=0, go to REFILL.
- REFILL:
  - Hold mem_en_out and mem_addr_out until valid_in.
  - On each valid_in: write the word at beat position, capture it if beat == requested offset, beat+1, mem_addr_out+=4.
  - After the last beat: mem_en_out<=0, set tag and valid, go to IDLE, rdy_out<=1, miss_out<=0, inst_out<=captured word.
- miss_out returns to 1 the cycle after any response.
- A new request may be accepted in the same cycle a response is presented.
- Flush:
  - IDLE with simultaneous en_in: request dropped.
  - LOOKUP: no response, no refill, go to IDLE.
  - REFILL: refill runs to completion and the line is installed; the response is suppressed (miss_out stays 1); rdy_out=0 until done.
- Reset mid-refill: abandon immediately; mem_en_out drops; the line stays invalid.
- Same-index different-tag request: evicts (direct mapped).
- Beat counter and address wrap only within the line; base alignment guarantees no carry into the index.

Optional Feature:
- Macro: ICACHE_STATS_EN.
- Defined: adds outputs icache_hit_cnt_out[31:0] and icache_miss_cnt_out[31:0], both reset 0.
  - Incremented once per non-flushed LOOKUP resolution (hit or miss respectively).
  - Wrap at 2^32.
  - Flushed lookups are not counted; a miss flushed during REFILL is still counted.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Cold miss: request 0x0000_1008; memory answers 0x1000..0x100C with 0xA0,0xA1,0xA2,0xA3 (1-cycle valid each). Required: 4 mem reads at line-aligned addresses, then miss_out=0 for one cycle with inst=0xA2, rdy_out=1.
- Hit after fill: request 0x0000_100C. Required: no mem_en_out; inst=0xA3 valid the cycle after edge k+1.
- Conflict eviction: request 0x0000_1408 (same index 0, tag differs). Required: refill from 0x1400; a following request to 0x1008 misses again.
- Flush during refill: flush asserted on the 2nd beat of a miss to 0x2000. Required: all 4 beats are consumed; no miss_out=0 pulse; a later 0x2004 request hits.
- Flush plus request in IDLE: en_in=1 with flush_in=1. Required: state remains IDLE, no mem request. rdy_in=0 for 3 cycles mid-refill: mem_en_out/addr are held and beats are not advanced.
- Async reset asserted during REFILL: outputs immediately return to reset values; after release, the previously filling line misses. With ICACHE_STATS_EN, the first two scenarios give hit=1, miss=1.
